// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, state encoding,
// the control-strobe bundle and small opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int OPC_W              = 5;
  localparam int MEM_WAIT_MAX_DFLT  = 15;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    T7     = 4'd8,
    S_WAIT = 4'd9,
    S_HALT = 4'd10
  } state_t;

  typedef struct packed {
    logic PCout;  logic Zlowout; logic Zhighout; logic MDRout; logic Cout;
    logic MARin;  logic PCin;    logic MDRin;    logic IRin;   logic Yin;
    logic Zin;    logic HIin;    logic LOin;     logic CONin;
    logic IncPC;  logic Read;    logic Write;
    logic Gra;    logic Grb;     logic Grc;      logic Rin;    logic Rout;
    logic BAout;  logic illegal;
  } ctrl_t;

  function automatic logic opc_defined(input logic [OPC_W-1:0] opc);
    logic d;
    case (opc)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_MUL, OP_BR, OP_NOP, OP_HALT: d = 1'b1;
      default:                                 d = 1'b0;
    endcase
    return d;
  endfunction

  // Final execute step of each opcode; NOP, HALT and undefined opcodes end at T2.
  function automatic state_t last_step(input logic [OPC_W-1:0] opc);
    state_t s;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: s = T5;
      OP_MUL, OP_BR:                                  s = T6;
      OP_LD, OP_ST:                                   s = T7;
      default:                                        s = T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore strobe decode: maps (state, opcode, con_ff) to the full control bundle.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opc,
  input  logic             con_ff,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1; end
      T1: begin ctrl.Zlowout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
      T2: begin
        ctrl.MDRout  = 1'b1;
        ctrl.IRin    = 1'b1;
        ctrl.illegal = !opc_defined(opc);
      end
      T3: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                    begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1;  ctrl.Yin = 1'b1;   end
        OP_LDI, OP_LD, OP_ST:
                    begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1;   end
        OP_MUL:     begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1;  ctrl.Yin = 1'b1;   end
        OP_BR:      begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1;  ctrl.CONin = 1'b1; end
        default: ;
      endcase
      T4: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR:
                    begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
        OP_ADDI, OP_LDI, OP_LD, OP_ST:
                    begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
        OP_MUL:     begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
        OP_BR:      begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
        default: ;
      endcase
      T5: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                    begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
        OP_LD, OP_ST:
                    begin ctrl.Zlowout = 1'b1; ctrl.MARin = 1'b1; end
        OP_MUL:     begin ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1; end
        OP_BR:      begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
        default: ;
      endcase
      T6: case (opc)
        OP_LD:      begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
        // Read low here steers the bus, not memory, into MDR.
        OP_ST:      begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
        OP_MUL:     begin ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1; end
        OP_BR:      begin ctrl.Zlowout = 1'b1; ctrl.PCin = con_ff; end
        default: ;
      endcase
      T7: case (opc)
        OP_LD:      begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
        OP_ST:      ctrl.Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: state register, memory wait/timeout counter,
// stop pause and halt handling around the combinational strobe decoder.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_done,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        run,
  output logic        mem_err,
  output logic        illegal,
  output state_t      state_dbg
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t           state, state_nxt, enter_t0;
  logic [CW-1:0]    wait_cnt;
  logic [OPC_W-1:0] opc;
  logic             mem_step, timeout;
  logic             unused_ir_bits;
  ctrl_t            ctrl;

  assign opc            = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];
  assign mem_step       = (state == T1) || (state == T6 && opc == OP_LD) ||
                          (state == T7 && opc == OP_ST);
  // stop is only looked at on the way into T0, i.e. at instruction boundaries.
  assign enter_t0       = stop ? S_WAIT : T0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      S_RST:  state_nxt = enter_t0;
      S_WAIT: if (!stop) state_nxt = T0;
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (mem_step && !mem_done) begin
          // This idle cycle brings the counter to MEM_WAIT_MAX: give up the access.
          if (wait_cnt == CW'(MEM_WAIT_MAX - 1)) begin
            timeout   = 1'b1;
            state_nxt = S_HALT;
          end
        end else if (state == T2 && opc == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (state == last_step(opc)) begin
          state_nxt = enter_t0;
        end else begin
          state_nxt = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (mem_step && !mem_done && !timeout) wait_cnt <= wait_cnt + CW'(1);
      else                                   wait_cnt <= '0;
      if (timeout) mem_err <= 1'b1;
    end
  end

  ctrl_decode u_decode (
    .state  (state),
    .opc    (opc),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  always_comb begin
    run = !(state == S_RST || state == S_WAIT || state == S_HALT);
    {PCout, Zlowout, Zhighout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin,
     Zin, HIin, LOin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
     BAout, illegal} = ctrl;
  end

  assign state_dbg = state;

  bus_single_driver: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({PCout, Zlowout, Zhighout, MDRout, Cout, Rout, BAout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table of inputs and
// expected state/strobes, plus hand-written async-reset sequences.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_done = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin;
  logic Zin, HIin, LOin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic run, mem_err, illegal;
  state_t state_dbg;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_done(mem_done), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .run(run), .mem_err(mem_err), .illegal(illegal), .state_dbg(state_dbg)
  );

  localparam logic [23:0] B_PCOUT = 24'h800000, B_ZLOW  = 24'h400000, B_ZHIGH = 24'h200000;
  localparam logic [23:0] B_MDROUT = 24'h100000, B_COUT = 24'h080000, B_MARIN = 24'h040000;
  localparam logic [23:0] B_PCIN  = 24'h020000, B_MDRIN = 24'h010000, B_IRIN  = 24'h008000;
  localparam logic [23:0] B_YIN   = 24'h004000, B_ZIN   = 24'h002000, B_HIIN  = 24'h001000;
  localparam logic [23:0] B_LOIN  = 24'h000800, B_CONIN = 24'h000400, B_INCPC = 24'h000200;
  localparam logic [23:0] B_READ  = 24'h000100, B_WRITE = 24'h000080, B_GRA   = 24'h000040;
  localparam logic [23:0] B_GRB   = 24'h000020, B_GRC   = 24'h000010, B_RIN   = 24'h000008;
  localparam logic [23:0] B_ROUT  = 24'h000004, B_BAOUT = 24'h000002, B_ILL   = 24'h000001;
  localparam logic [23:0] SB_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [23:0] SB_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
  localparam logic [23:0] SB_T2 = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_ADD  = 32'h18918000, IR_ADDI = 32'h60000000;
  localparam logic [31:0] IR_LDI  = 32'h08000000, IR_LD   = 32'h00800005;
  localparam logic [31:0] IR_ST   = 32'h10000000, IR_MUL  = 32'h78000000;
  localparam logic [31:0] IR_BR   = 32'h90000000, IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000, IR_BAD  = 32'hF8000000;

  typedef struct {
    logic [31:0] ir;
    logic        md, cf, stp;
    state_t      st;
    logic [23:0] sb;
    logic        run, err;
  } vec_t;

  vec_t  vecs[$];
  string tags[$];
  int    n_vec = 0, n_err = 0;

  function automatic logic [23:0] act_sb();
    return {PCout, Zlowout, Zhighout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin,
            Zin, HIin, LOin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
            BAout, illegal};
  endfunction

  task automatic check(input string tag, input state_t st, input logic [23:0] sb,
                       input logic r, input logic e);
    n_vec++;
    if ({state_dbg, act_sb(), run, mem_err} !== {st, sb, r, e}) begin
      n_err++;
      $display("FAIL %s: got state=%0d strobes=%h run=%b mem_err=%b, expected state=%0d strobes=%h run=%b mem_err=%b",
               tag, state_dbg, act_sb(), run, mem_err, st, sb, r, e);
    end
  endtask

  task automatic add(input string tag, input logic [31:0] ir_v, input logic md,
                     input logic cf, input logic stp, input state_t st,
                     input logic [23:0] sb, input logic r, input logic e);
    vec_t v;
    v.ir = ir_v; v.md = md; v.cf = cf; v.stp = stp;
    v.st = st; v.sb = sb; v.run = r; v.err = e;
    vecs.push_back(v);
    tags.push_back(tag);
  endtask

  // T0..T2 with memory answering at once; mem_done high in T0/T2 must be ignored.
  task automatic add_fetch(input string tag, input logic [31:0] ir_v, input logic cf,
                           input logic [23:0] t2_extra);
    add(tag, ir_v, 1'b1, cf, 1'b0, T0, SB_T0, 1'b1, 1'b0);
    add(tag, ir_v, 1'b1, cf, 1'b0, T1, SB_T1, 1'b1, 1'b0);
    add(tag, ir_v, 1'b1, cf, 1'b0, T2, SB_T2 | t2_extra, 1'b1, 1'b0);
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      @(negedge clk);
      ir = vecs[i].ir; mem_done = vecs[i].md; con_ff = vecs[i].cf; stop = vecs[i].stp;
      #1 check($sformatf("%s[%0d]", tags[i], i), vecs[i].st, vecs[i].sb, vecs[i].run, vecs[i].err);
    end
    vecs.delete();
    tags.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check("reset", S_RST, '0, 1'b0, 1'b0);
    rst = 1'b1;

    // ADD R1,R2,R3: T0..T5 then T0 on the seventh cycle.
    add_fetch("add", IR_ADD, 1'b0, '0);
    add("add", IR_ADD, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_ROUT | B_YIN, 1'b1, 1'b0);
    add("add", IR_ADD, 1'b1, 1'b0, 1'b0, T4, B_GRC | B_ROUT | B_ZIN, 1'b1, 1'b0);
    add("add", IR_ADD, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_GRA | B_RIN, 1'b1, 1'b0);
    add_fetch("addi", IR_ADDI, 1'b0, '0);
    add("addi", IR_ADDI, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_ROUT | B_YIN, 1'b1, 1'b0);
    add("addi", IR_ADDI, 1'b1, 1'b0, 1'b0, T4, B_COUT | B_ZIN, 1'b1, 1'b0);
    add("addi", IR_ADDI, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_GRA | B_RIN, 1'b1, 1'b0);
    add_fetch("ldi", IR_LDI, 1'b0, '0);
    add("ldi", IR_LDI, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_BAOUT | B_YIN, 1'b1, 1'b0);
    add("ldi", IR_LDI, 1'b1, 1'b0, 1'b0, T4, B_COUT | B_ZIN, 1'b1, 1'b0);
    add("ldi", IR_LDI, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_GRA | B_RIN, 1'b1, 1'b0);

    // LD with memory three cycles late in both T1 and T6.
    add("ld", IR_LD, 1'b1, 1'b0, 1'b0, T0, SB_T0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      add("ld_t1", IR_LD, (k == 3), 1'b0, 1'b0, T1, SB_T1, 1'b1, 1'b0);
    add("ld", IR_LD, 1'b1, 1'b0, 1'b0, T2, SB_T2, 1'b1, 1'b0);
    add("ld", IR_LD, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_BAOUT | B_YIN, 1'b1, 1'b0);
    add("ld", IR_LD, 1'b1, 1'b0, 1'b0, T4, B_COUT | B_ZIN, 1'b1, 1'b0);
    add("ld", IR_LD, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_MARIN, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      add("ld_t6", IR_LD, (k == 3), 1'b0, 1'b0, T6, B_READ | B_MDRIN, 1'b1, 1'b0);
    add("ld", IR_LD, 1'b0, 1'b0, 1'b0, T7, B_MDROUT | B_GRA | B_RIN, 1'b1, 1'b0);

    // BR with the condition false, then true.
    for (int c = 0; c < 2; c++) begin
      add_fetch("br", IR_BR, c[0], '0);
      add("br", IR_BR, 1'b1, c[0], 1'b0, T3, B_GRA | B_ROUT | B_CONIN, 1'b1, 1'b0);
      add("br", IR_BR, 1'b1, c[0], 1'b0, T4, B_PCOUT | B_YIN, 1'b1, 1'b0);
      add("br", IR_BR, 1'b1, c[0], 1'b0, T5, B_COUT | B_ZIN, 1'b1, 1'b0);
      add("br_t6", IR_BR, 1'b1, c[0], 1'b0, T6, B_ZLOW | (c[0] ? B_PCIN : 24'h0), 1'b1, 1'b0);
    end

    // MUL with stop raised mid-instruction: finishes, then pauses.
    add_fetch("mul", IR_MUL, 1'b0, '0);
    add("mul", IR_MUL, 1'b1, 1'b0, 1'b0, T3, B_GRA | B_ROUT | B_YIN, 1'b1, 1'b0);
    add("mul", IR_MUL, 1'b1, 1'b0, 1'b1, T4, B_GRB | B_ROUT | B_ZIN, 1'b1, 1'b0);
    add("mul", IR_MUL, 1'b1, 1'b0, 1'b1, T5, B_ZLOW | B_LOIN, 1'b1, 1'b0);
    add("mul", IR_MUL, 1'b1, 1'b0, 1'b1, T6, B_ZHIGH | B_HIIN, 1'b1, 1'b0);
    add("wait", IR_MUL, 1'b1, 1'b0, 1'b1, S_WAIT, '0, 1'b0, 1'b0);
    add("wait", IR_MUL, 1'b1, 1'b0, 1'b0, S_WAIT, '0, 1'b0, 1'b0);
    add_fetch("nop", IR_NOP, 1'b0, '0);

    // ST whose write never completes: 15 idle cycles in T7, then halt.
    add_fetch("st", IR_ST, 1'b0, '0);
    add("st", IR_ST, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_BAOUT | B_YIN, 1'b1, 1'b0);
    add("st", IR_ST, 1'b1, 1'b0, 1'b0, T4, B_COUT | B_ZIN, 1'b1, 1'b0);
    add("st", IR_ST, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_MARIN, 1'b1, 1'b0);
    add("st", IR_ST, 1'b1, 1'b0, 1'b0, T6, B_GRA | B_ROUT | B_MDRIN, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++)
      add("st_t7", IR_ST, 1'b0, 1'b0, 1'b0, T7, B_WRITE, 1'b1, 1'b0);
    add("st_to", IR_ST, 1'b0, 1'b0, 1'b1, S_HALT, '0, 1'b0, 1'b1);
    add("st_to", IR_ST, 1'b1, 1'b0, 1'b0, S_HALT, '0, 1'b0, 1'b1);
    apply_vecs();

    // Reset clears the sticky timeout flag.
    @(negedge clk); rst = 1'b0;
    #1 check("rst_clr", S_RST, '0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Async reset while LD waits in T6: Read/MDRin must drop without a clock.
    add_fetch("ld2", IR_LD, 1'b0, '0);
    add("ld2", IR_LD, 1'b1, 1'b0, 1'b0, T3, B_GRB | B_BAOUT | B_YIN, 1'b1, 1'b0);
    add("ld2", IR_LD, 1'b1, 1'b0, 1'b0, T4, B_COUT | B_ZIN, 1'b1, 1'b0);
    add("ld2", IR_LD, 1'b1, 1'b0, 1'b0, T5, B_ZLOW | B_MARIN, 1'b1, 1'b0);
    add("ld2", IR_LD, 1'b0, 1'b0, 1'b0, T6, B_READ | B_MDRIN, 1'b1, 1'b0);
    add("ld2", IR_LD, 1'b0, 1'b0, 1'b0, T6, B_READ | B_MDRIN, 1'b1, 1'b0);
    apply_vecs();
    #1 rst = 1'b0;
    #1 check("rst_async", S_RST, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1 check("rst_held", S_RST, '0, 1'b0, 1'b0);
    rst = 1'b1;

    // Undefined opcode pulses illegal in T2 only; HALT then parks the CPU.
    add_fetch("bad", IR_BAD, 1'b0, B_ILL);
    add_fetch("halt", IR_HALT, 1'b0, '0);
    add("halt", IR_HALT, 1'b1, 1'b0, 1'b1, S_HALT, '0, 1'b0, 1'b0);
    add("halt", IR_HALT, 1'b1, 1'b0, 1'b0, S_HALT, '0, 1'b0, 1'b0);
    add("halt", IR_ADD, 1'b1, 1'b0, 1'b0, S_HALT, '0, 1'b0, 1'b0);
    apply_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
